// File: rtl/requant_pkg.sv
// Shared constants and types for the signed narrowing (requantize) blocks.
package requant_pkg;

  localparam int DEF_IN_W = 8;

  // Stage-1 extended word for the default input width: IN_W data bits plus
  // headroom for the sign bit of unsigned inputs and the round-bias carry.
  typedef logic signed [DEF_IN_W+1:0] ext_word_t;

  function automatic int out_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int out_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational clamp of a wide signed word into an OUT_W signed result,
// flagging when the value had to be clamped.
module requant_sat
  import requant_pkg::*;
#(
  parameter int EXT_W = 10,
  parameter int OUT_W = 4
) (
  input  logic signed [EXT_W-1:0] ext,
  output logic        [OUT_W-1:0] res,
  output logic                    sat
);

  localparam logic signed [EXT_W-1:0] MAXV = EXT_W'(out_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MINV = EXT_W'(out_min(OUT_W));

  always_comb begin
    res = ext[OUT_W-1:0];
    sat = 1'b0;
    if (ext > MAXV) begin
      res = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (ext < MINV) begin
      res = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/signed_requant.sv
// Two-stage valid/ready requantizer: extend, (optionally round), shift, clamp.
// Build option: define REQUANT_ROUND_EN to add the round-half-up bias in stage 1.
module signed_requant
  import requant_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 4,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_signed,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
  output logic [CNT_W-1:0]   sat_count,
  input  logic               clr_count
);

  localparam int EXT_W = IN_W + 2;
  typedef logic signed [EXT_W-1:0] ext_t;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;
  ext_t             s1_word;
  ext_t             ext_in;
  ext_t             shifted;
  logic [OUT_W-1:0] sat_res;
  logic             sat_flag;

  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;

  always_comb begin
    ext_in = $signed({{2{in_signed & in_data[IN_W-1]}}, in_data});
`ifdef REQUANT_ROUND_EN
    if (shift != '0) ext_in = ext_in + (ext_t'(1) <<< (shift - SHIFT_W'(1)));
`endif
    shifted = ext_in >>> shift;
  end

  requant_sat #(
    .EXT_W (EXT_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .ext (s1_word),
    .res (sat_res),
    .sat (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_word  <= shifted;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
        out_data <= sat_res;
        out_sat  <= sat_flag;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle saturating handshake; the count sticks at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (s2_valid & out_ready & out_sat & ~&sat_count) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_signed_requant.sv
// Scoreboard bench for signed_requant: driver pushes model results on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_signed_requant;

  localparam int IN_W = 8, OUT_W = 4, SHIFT_W = 3, CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 0;
  logic               rst_n = 0;
  logic               in_valid = 0;
  logic               in_ready;
  logic [IN_W-1:0]    in_data = '0;
  logic               in_signed = 0;
  logic [SHIFT_W-1:0] shift = '0;
  logic               out_valid;
  logic               out_ready = 1;
  logic [OUT_W-1:0]   out_data;
  logic               out_sat;
  logic [CNT_W-1:0]   sat_count;
  logic               clr_count = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OUT_W:0] exp_q[$];
  int             cnt_model = 0;
  logic           hold_valid = 0;
  logic [OUT_W:0] hold_word = '0;

  signed_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_count(sat_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  // Reference: exact integer value, divide by 2^shift rounding down (or half-up), clamp.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic sg,
                                           input logic [SHIFT_W-1:0] sh);
    int v;
    logic [OUT_W-1:0] q;
    logic s;
    v = sg ? int'($signed(d)) : int'(d);
`ifdef REQUANT_ROUND_EN
    if (sh != 0) v = v + (1 << (int'(sh) - 1));
`endif
    v = v >>> sh;
    s = 1'b1;
    if (v > (1 << (OUT_W - 1)) - 1) v = (1 << (OUT_W - 1)) - 1;
    else if (v < -(1 << (OUT_W - 1))) v = -(1 << (OUT_W - 1));
    else s = 1'b0;
    q = v[OUT_W-1:0];
    return {s, q};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_data, in_signed, shift));
  end

  always @(negedge clk) begin
    logic [OUT_W:0] e;
    if (!rst_n) begin
      exp_q.delete();
      cnt_model = 0;
      hold_valid = 0;
    end else begin
      n_checks++;
      if (sat_count !== CNT_W'(cnt_model)) begin
        n_fail++;
        $display("FAIL sat_count: got %0d expected %0d", sat_count, cnt_model);
      end
      if (hold_valid && out_valid) begin
        n_checks++;
        if ({out_sat, out_data} !== hold_word) begin
          n_fail++;
          $display("FAIL stall_stable: got %0h expected %0h", {out_sat, out_data}, hold_word);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", {out_sat, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_sat, out_data} !== e) begin
            n_fail++;
            $display("FAIL scoreboard: got sat=%0b data=%0h expected sat=%0b data=%0h",
                     out_sat, out_data, e[OUT_W], e[OUT_W-1:0]);
          end
          if (clr_count) cnt_model = 0;
          else if (e[OUT_W] && cnt_model < CNT_MAX) cnt_model++;
        end
        hold_valid = 0;
      end else begin
        if (clr_count) cnt_model = 0;
        hold_valid = out_valid;
        hold_word  = {out_sat, out_data};
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic wait_accept(input string name);
    int  g = 0;
    logic acc = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; g++;
    end while (!acc && g < 200);
    in_valid = 0;
    if (!acc) check({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic drive(input logic [IN_W-1:0] d, input logic sg, input logic [SHIFT_W-1:0] sh);
    in_valid = 1; in_data = d; in_signed = sg; shift = sh;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic sg, input logic [SHIFT_W-1:0] sh);
    drive(d, sg, sh);
    wait_accept("send");
  endtask

  // Empty pipeline, out_ready high: output must appear exactly two cycles later.
  task automatic send_check(input string name, input logic [IN_W-1:0] d, input logic sg,
                            input logic [SHIFT_W-1:0] sh, input logic [OUT_W-1:0] q,
                            input logic s);
    out_ready = 1;
    send(d, sg, sh);
    @(negedge clk);
    check({name, "_lat_early"}, 32'(out_valid), 0);
    @(negedge clk);
    check({name, "_lat_valid"}, 32'(out_valid), 1);
    check({name, "_data"}, 32'(out_data), 32'(q));
    check({name, "_sat"}, 32'(out_sat), 32'(s));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) check("drain_timeout", 0, 1);
  endtask

  task automatic random_stream(input int n);
    int   sent = 0;
    int   g = 0;
    logic acc;
    while (sent < n && g < 2000) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1; g++;
      if (acc) sent++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if (sent < n) drive(IN_W'($urandom), 1'($urandom), SHIFT_W'($urandom));
        else in_valid = 0;
      end
    end
    in_valid = 0;
    if (g >= 2000) check("stream_timeout", 0, 1);
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_sat_count", 32'(sat_count), 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

`ifdef REQUANT_ROUND_EN
    send_check("u13_sh1", 8'd13, 1, 1, 4'd7, 0);
    send_check("neg_sh2", 8'hF3, 1, 2, 4'hD, 0);
`else
    send_check("u13_sh1", 8'd13, 1, 1, 4'd6, 0);
    send_check("neg_sh2", 8'hF3, 1, 2, 4'hC, 0);
`endif
    send_check("sat_signed", 8'hF3, 1, 0, 4'h8, 1);
    send_check("sat_unsigned", 8'hF3, 0, 0, 4'h7, 1);
    drain();
    check("sat_count_two", 32'(sat_count), 2);

    // Backpressure: two accepted, third blocked until the consumer resumes.
    out_ready = 0;
    send(8'h10, 1, 0);
    send(8'h85, 0, 5);
    drive(8'hF9, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_accept("bp_third");
    drain();

    // Counter saturation then clear-priority over a saturating handshake.
    clr_count = 1; @(posedge clk); #1; clr_count = 0;
    for (int i = 0; i < 5; i++) send(8'h80, 1, 0);
    drain();
    check("cnt_sticky_max", 32'(sat_count), CNT_MAX);
    out_ready = 0;
    send(8'h7F, 1, 0);
    @(posedge clk); #1;
    check("clr_pending_valid", 32'(out_valid), 1);
    out_ready = 1; clr_count = 1;
    @(posedge clk); #1;
    clr_count = 0;
    check("clr_priority", 32'(sat_count), 0);
    drain();

    // Reset with both stages full.
    send(8'hF3, 1, 0);
    drain();
    out_ready = 0;
    send(8'h40, 1, 0);
    send(8'h22, 0, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_sat_count", 32'(sat_count), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send_check("post_rst", 8'd40, 1, 3, 4'd5, 0);

    random_stream(16);
    drain();
    random_stream(48);
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
